// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the bit-serial ALU sequencer.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Subtract-style ops feed ~b with carry-in 1.
  function automatic logic inverts_b(input logic [3:0] op);
    return (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: full adder for ADD/SUB/SLT, bitwise logic otherwise.
import alu_pkg::*;

module alu_bit_slice (
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [3:0] aluop,
  output logic       r,
  output logic       cout
);

  always_comb begin
    r    = 1'b0;
    cout = 1'b0;
    case (aluop)
      OP_ADD, OP_SUB, OP_SLT: begin
        r    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOR: r = ~(a | b);
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: one slice, LSB-first, start/busy/done handshake.
// Optional zero/ovf flag ports are enabled with ALU_SERIAL_FLAGS_EN.
//
//  state    | meaning
//  ST_IDLE  | waiting for start; operands captured on accept
//  ST_SHIFT | one result bit per cycle, cnt 0..WIDTH-1
//  ST_DONE  | done pulse, result valid; back to idle
import alu_pkg::*;

module alu_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
`ifdef ALU_SERIAL_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic [WIDTH-2:0] shreg_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] result_q;

  logic             slice_b, slice_r, slice_cout;
  logic             ovf_bit, slt_bit;
  logic [WIDTH-1:0] shreg_d, result_d;

  assign slice_b = b_q[0] ^ inverts_b(op_q);

  alu_bit_slice u_slice (
    .a     (a_q[0]),
    .b     (slice_b),
    .cin   (carry_q),
    .aluop (op_q),
    .r     (slice_r),
    .cout  (slice_cout)
  );

  // On the last bit carry_q is the MSB carry-in, so this is signed overflow.
  assign ovf_bit  = carry_q ^ slice_cout;
  assign slt_bit  = slice_r ^ ovf_bit;
  assign shreg_d  = {slice_r, shreg_q};
  assign result_d = (op_q == OP_SLT) ? {{(WIDTH-1){1'b0}}, slt_bit} : shreg_d;

`ifdef ALU_SERIAL_FLAGS_EN
  logic zero_q, ovf_q, ovf_d;
  assign ovf_d = ((op_q == OP_ADD) || (op_q == OP_SUB)) & ovf_bit;
  assign zero  = zero_q;
  assign ovf   = ovf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zero_q <= 1'b1;
      ovf_q  <= 1'b0;
    end else if (state_q == ST_SHIFT && cnt_q == CNT_LAST) begin
      zero_q <= (result_d == '0);
      ovf_q  <= ovf_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      shreg_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= aluop;
            cnt_q   <= '0;
            carry_q <= inverts_b(aluop);
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          shreg_q <= shreg_d[WIDTH-1:1];
          carry_q <= slice_cout;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q  <= ST_DONE;
            done_q   <= 1'b1;
            result_q <= result_d;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Scoreboard bench for alu_serial_ctrl: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_alu_serial_ctrl;

  localparam int W      = 32;
  localparam int PERIOD = W + 2;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [3:0]   aluop;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] result;
`ifdef ALU_SERIAL_FLAGS_EN
  logic         zero, ovf;
`endif

  always #5 clk = ~clk;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .aluop  (aluop),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
`ifdef ALU_SERIAL_FLAGS_EN
    ,
    .zero   (zero),
    .ovf    (ovf)
`endif
  );

  typedef struct {
    int           acc;
    logic [W-1:0] res;
    logic         z;
    logic         v;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           last_acc = -1000;
  int           next_ok = 0;
  logic [W-1:0] hold_res = '0;
  logic         prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference: plain integer arithmetic on the whole word.
  function automatic exp_t model(input int acc, input logic [3:0] op,
                                 input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e.acc = acc;
    e.v   = 1'b0;
    case (op)
      4'd0: begin
        e.res = x + y;
        e.v   = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
      end
      4'd1: begin
        e.res = x - y;
        e.v   = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
      end
      4'd4: e.res = x & y;
      4'd5: e.res = x | y;
      4'd6: e.res = x ^ y;
      4'd7: e.res = ~(x | y);
      4'd8: e.res = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      default: e.res = '0;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      exp_t e;
      chk("busy", 64'(busy), 64'((cyc >= last_acc) && (cyc <= last_acc + W)));
      if (done) begin
        chk("done_single_cycle", 64'(prev_done), 64'(0));
        if (sb.size() == 0) begin
          chk("done_unexpected", 64'(done), 64'(0));
        end else begin
          e = sb.pop_front();
          chk("latency", 64'(cyc - e.acc), 64'(W));
          chk("result", 64'(result), 64'(e.res));
`ifdef ALU_SERIAL_FLAGS_EN
          chk("zero", 64'(zero), 64'(e.z));
          chk("ovf", 64'(ovf), 64'(e.v));
`endif
          hold_res = e.res;
        end
      end else begin
        chk("result_hold", 64'(result), 64'(hold_res));
        if (sb.size() > 0 && cyc > sb[0].acc + W) begin
          chk("done_missing", 64'(done), 64'(1));
          void'(sb.pop_front());
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] x,
                       input logic [W-1:0] y, input bit hold);
    aluop = op;
    a     = x;
    b     = y;
    start = 1'b1;
    while (cyc + 1 < next_ok) @(negedge clk);
    last_acc = cyc + 1;
    next_ok  = cyc + 1 + PERIOD;
    sb.push_back(model(cyc + 1, op, x, y));
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return '1;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    start = 1'b0;
    aluop = 4'd0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
`ifdef ALU_SERIAL_FLAGS_EN
    chk("rst_zero", 64'(zero), 64'(1));
    chk("rst_ovf", 64'(ovf), 64'(0));
`endif
    reset = 1'b0;
    @(negedge clk);

    // Abort an ADD at cnt=10, then rerun it cleanly.
    issue(4'd0, 32'd5, 32'd3, 1'b0);
    repeat (10) @(negedge clk);
    reset    = 1'b1;
    sb.delete();
    last_acc = -1000;
    next_ok  = 0;
    hold_res = '0;
    #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_result", 64'(result), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    issue(4'd0, 32'd5, 32'd3, 1'b0);

    issue(4'd0, 32'h7FFF_FFFF, 32'h1, 1'b0);
    issue(4'd1, 32'h0, 32'h1, 1'b0);
    issue(4'd4, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0);
    issue(4'd5, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0);
    issue(4'd6, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0);
    issue(4'd7, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b0);
    issue(4'd8, 32'hFFFF_FFFE, 32'h1, 1'b0);
    issue(4'd8, 32'd5, 32'd5, 1'b0);
    issue(4'd8, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    issue(4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    // start held high across several operations.
    issue(4'd0, 32'h1234_5678, 32'h0FED_CBA9, 1'b1);
    issue(4'd1, 32'h8000_0000, 32'h1, 1'b1);
    issue(4'd6, 32'hAAAA_5555, 32'hFFFF_0000, 1'b0);

    // A start pulse mid-SHIFT must be ignored.
    issue(4'd5, 32'h0000_F000, 32'h0000_000F, 1'b0);
    repeat (5) @(negedge clk);
    aluop = 4'd0;
    a     = 32'hDEAD_BEEF;
    b     = 32'h1111_1111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    for (int i = 0; i < 30; i++) begin
      issue(4'($urandom_range(0, 15)), rnd_operand(), rnd_operand(), bit'($urandom_range(0, 1)));
    end
    start = 1'b0;

    for (int i = 0; i < 4 * PERIOD && sb.size() > 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
